// File: rtl/jseq_pkg.sv
// Shared types and default sizing for the Johnson sequence controller.
package jseq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StHold,
        StDone
    } state_t;

    localparam int unsigned DefWidth = 4;
    localparam int unsigned DefRotW  = 8;

endpackage

// File: rtl/johnson_core.sv
// Johnson shift register with synchronous clear and forward/reverse stepping.
module johnson_core
    import jseq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             dir,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            if (dir) begin
                q <= {~q[0], q[WIDTH-1:1]};
            end else begin
                q <= {q[WIDTH-2:0], ~q[WIDTH-1]};
            end
        end
    end

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Runs a Johnson counter for a requested number of full rotations.
// Define JSEQ_REVERSE_EN to add the dir input for reverse stepping.
module johnson_seq_ctrl
    import jseq_pkg::*;
#(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned ROT_W = DefRotW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ROT_W-1:0]   num_rot,
    input  logic               pause,
    input  logic               abort,
`ifdef JSEQ_REVERSE_EN
    input  logic               dir,
`endif
    output logic [WIDTH-1:0]   q,
    output logic [2*WIDTH-1:0] phase,
    output logic [ROT_W-1:0]   rot_cnt,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [ROT_W-1:0]   num_q, num_d;
    logic [ROT_W-1:0]   rot_q, rot_d;
    logic               dir_q, dir_d;
    logic               dir_in;
    logic               step;
    logic               clr;
    logic               last_step;

`ifdef JSEQ_REVERSE_EN
    assign dir_in = dir;
`else
    assign dir_in = 1'b0;
`endif

    johnson_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk(clk),
        .rst(rst),
        .en (step),
        .clr(clr),
        .dir(dir_q),
        .q  (q)
    );

    // Final entry of the active sequence: the next advance wraps q back to zero.
    assign last_step = dir_q ? (q == {{(WIDTH-1){1'b0}}, 1'b1})
                             : (q == {1'b1, {(WIDTH-1){1'b0}}});

    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        rot_d   = rot_q;
        dir_d   = dir_q;
        step    = 1'b0;
        clr     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_d   = num_rot;
                    rot_d   = '0;
                    dir_d   = dir_in;
                    state_d = (num_rot != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                busy = 1'b1;
                if (abort) begin
                    clr     = 1'b1;
                    state_d = StIdle;
                end else if (pause) begin
                    state_d = StHold;
                end else begin
                    step = 1'b1;
                    if (last_step) begin
                        rot_d = rot_q + ROT_W'(1);
                        if (rot_d == num_q) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StHold: begin
                busy = 1'b1;
                if (abort) begin
                    clr     = 1'b1;
                    state_d = StIdle;
                end else if (!pause) begin
                    state_d = StRun;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            num_q   <= '0;
            rot_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            rot_q   <= rot_d;
            dir_q   <= dir_d;
        end
    end

    function automatic logic [WIDTH-1:0] seq_entry(int unsigned k, logic rev);
        logic [WIDTH-1:0] f;
        logic [WIDTH-1:0] r;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            f[i] = (k <= WIDTH) ? (i < k) : (i >= k - WIDTH);
        end
        for (int unsigned i = 0; i < WIDTH; i++) begin
            r[i] = f[WIDTH-1-i];
        end
        return rev ? r : f;
    endfunction

    for (genvar k = 0; k < 2 * WIDTH; k++) begin : g_phase
        assign phase[k] = (q == seq_entry(k, dir_q));
    end

    assign rot_cnt = rot_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Self-checking bench for johnson_seq_ctrl (WIDTH=4, ROT_W=8) against a
// position/rotation model of the run.
module tb_johnson_seq_ctrl;

    localparam int WIDTH = 4;
    localparam int ROT_W = 8;
    localparam int STEPS = 2 * WIDTH;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ROT_W-1:0] num_rot;
    logic             pause;
    logic             abort;
    logic             dir;
    logic [WIDTH-1:0] q;
    logic [STEPS-1:0] phase;
    logic [ROT_W-1:0] rot_cnt;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    // Behavioural model: position within the rotation plus rotation bookkeeping.
    bit m_active, m_hold, m_done, m_dir;
    int m_pos, m_rot, m_num;

    johnson_seq_ctrl #(
        .WIDTH(WIDTH),
        .ROT_W(ROT_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .num_rot(num_rot),
        .pause  (pause),
        .abort  (abort),
`ifdef JSEQ_REVERSE_EN
        .dir    (dir),
`endif
        .q      (q),
        .phase  (phase),
        .rot_cnt(rot_cnt),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ent(int idx, bit rev);
        int v;
        logic [WIDTH-1:0] f;
        if (idx <= WIDTH) v = (1 << idx) - 1;
        else              v = ((1 << WIDTH) - 1) & ~((1 << (idx - WIDTH)) - 1);
        f = v[WIDTH-1:0];
        return rev ? {f[0], f[1], f[2], f[3]} : f;
    endfunction

    function automatic void model_reset();
        m_active = 0; m_hold = 0; m_done = 0; m_dir = 0;
        m_pos = 0; m_rot = 0; m_num = 0;
    endfunction

    function automatic void model_step();
        if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (start) begin
                m_rot = 0;
                m_num = int'(num_rot);
                m_dir = dir;
                if (num_rot != 0) begin
                    m_active = 1; m_hold = 0; m_pos = 0;
                end else begin
                    m_done = 1;
                end
            end
        end else if (abort) begin
            m_active = 0; m_hold = 0; m_pos = 0;
        end else if (m_hold) begin
            if (!pause) m_hold = 0;
        end else if (pause) begin
            m_hold = 1;
        end else begin
            m_pos = (m_pos + 1) % STEPS;
            if (m_pos == 0) begin
                m_rot++;
                if (m_rot == m_num) begin
                    m_active = 0; m_done = 1;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        start = 0; num_rot = '0; pause = 0; abort = 0; dir = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        model_reset();
        #3;
        total += 5;
        if (q !== 4'b0000) begin bad++; $display("FAIL reset_q got=%b want=0000", q); end
        if (phase !== 8'h01) begin bad++; $display("FAIL reset_phase got=%b want=00000001", phase); end
        if (rot_cnt !== 8'd0) begin bad++; $display("FAIL reset_rot got=%0d want=0", rot_cnt); end
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_single_rot();
        int busy_n = 0, done_n = 0, done_at = -1;
        start = 1; num_rot = 8'd1;
        tick();
        start = 0;
        for (int c = 0; c < 16; c++) begin
            if (busy) busy_n++;
            if (done) begin done_n++; done_at = c; end
            if (c >= 1 && c <= 8) begin
                total++;
                if (q !== ent(c % STEPS, 0)) begin
                    bad++; $display("FAIL single_q c=%0d got=%b want=%b", c, q, ent(c % STEPS, 0));
                end
            end
            tick();
        end
        total += 4;
        if (busy_n != 8) begin bad++; $display("FAIL single_busy got=%0d want=8", busy_n); end
        if (done_n != 1 || done_at != 8) begin
            bad++; $display("FAIL single_done got=%0d@%0d want=1@8", done_n, done_at);
        end
        if (rot_cnt !== 8'd1) begin bad++; $display("FAIL single_rot got=%0d want=1", rot_cnt); end
        if (q !== 4'b0000) begin bad++; $display("FAIL single_end_q got=%b want=0000", q); end
    endtask

    task automatic test_multi_rot();
        int busy_n = 0, done_at = -1;
        start = 1; num_rot = 8'd3;
        tick();
        start = 0;
        for (int c = 0; c < 40; c++) begin
            if (busy) busy_n++;
            if (done && done_at < 0) done_at = c;
            if (c == 8 || c == 16 || c == 24) begin
                total++;
                if (rot_cnt !== 8'(c / 8)) begin
                    bad++; $display("FAIL multi_rot c=%0d got=%0d want=%0d", c, rot_cnt, c / 8);
                end
            end
            tick();
        end
        total += 3;
        if (busy_n != 24) begin bad++; $display("FAIL multi_busy got=%0d want=24", busy_n); end
        if (done_at != 24) begin bad++; $display("FAIL multi_done_at got=%0d want=24", done_at); end
        if (rot_cnt !== 8'd3) begin bad++; $display("FAIL multi_rot_hold got=%0d want=3", rot_cnt); end
    endtask

    task automatic test_zero_rot();
        int busy_n = 0;
        start = 1; num_rot = 8'd0;
        tick();
        start = 0;
        total += 2;
        if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b want=1", done); end
        if (q !== 4'b0000) begin bad++; $display("FAIL zero_q got=%b want=0000", q); end
        for (int c = 0; c < 4; c++) begin
            if (busy) busy_n++;
            tick();
        end
        total += 2;
        if (busy_n != 0) begin bad++; $display("FAIL zero_busy got=%0d want=0", busy_n); end
        if (done !== 1'b0) begin bad++; $display("FAIL zero_done_clear got=%b want=0", done); end
    endtask

    task automatic test_pause();
        int busy_n = 0, guard = 0;
        start = 1; num_rot = 8'd1;
        tick();
        start = 0;
        while (q !== 4'b0111 && guard < 20) begin
            busy_n++; tick(); guard++;
        end
        total++;
        if (guard >= 20) begin bad++; $display("FAIL pause_reach got=%b want=0111", q); end
        // 4 paused edges plus the resume edge leave q frozen for 5 extra cycles.
        pause = 1;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) pause = 0;
            if (busy) busy_n++;
            tick();
            total += 2;
            if (q !== 4'b0111) begin bad++; $display("FAIL pause_hold_q c=%0d got=%b want=0111", c, q); end
            if (busy !== 1'b1) begin bad++; $display("FAIL pause_busy c=%0d got=%b want=1", c, busy); end
        end
        guard = 0;
        while (busy && guard < 30) begin
            busy_n++; tick(); guard++;
        end
        total += 2;
        if (busy_n != 13) begin bad++; $display("FAIL pause_total got=%0d want=13", busy_n); end
        if (done !== 1'b1) begin bad++; $display("FAIL pause_done got=%b want=1", done); end
        tick();
    endtask

    task automatic test_abort();
        int guard = 0, done_n = 0;
        start = 1; num_rot = 8'd1;
        tick();
        start = 0;
        while (q !== 4'b1110 && guard < 20) begin tick(); guard++; end
        pause = 1;
        tick();
        abort = 1;
        tick();
        abort = 0; pause = 0;
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        if (q !== 4'b0000) begin bad++; $display("FAIL abort_q got=%b want=0000", q); end
        if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done); end
        start = 1; num_rot = 8'd1;
        tick();
        start = 0;
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL abort_restart got=%b want=1", busy); end
        for (int c = 0; c < 12; c++) begin
            if (done) done_n++;
            tick();
        end
        total++;
        if (done_n != 1) begin bad++; $display("FAIL abort_rerun_done got=%0d want=1", done_n); end
    endtask

    task automatic test_max_rot();
        int busy_n = 0, done_n = 0;
        start = 1; num_rot = 8'd255;
        tick();
        start = 0;
        for (int c = 0; c < 2060; c++) begin
            if (busy) busy_n++;
            if (done) done_n++;
            tick();
        end
        total += 3;
        if (busy_n != 2040) begin bad++; $display("FAIL max_busy got=%0d want=2040", busy_n); end
        if (done_n != 1) begin bad++; $display("FAIL max_done got=%0d want=1", done_n); end
        if (rot_cnt !== 8'd255) begin bad++; $display("FAIL max_rot got=%0d want=255", rot_cnt); end
    endtask

    task automatic test_reset_midrun();
        int done_n = 0;
        start = 1; num_rot = 8'd2;
        tick();
        start = 0;
        for (int c = 0; c < 10; c++) tick();
        #2 rst = 1'b0;
        #1;
        model_reset();
        total += 3;
        if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b want=0", busy); end
        if (q !== 4'b0000) begin bad++; $display("FAIL midreset_q got=%b want=0000", q); end
        if (rot_cnt !== 8'd0) begin bad++; $display("FAIL midreset_rot got=%0d want=0", rot_cnt); end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (done || busy) done_n++;
            tick();
        end
        total++;
        if (done_n != 0) begin bad++; $display("FAIL midreset_quiet got=%0d want=0", done_n); end
    endtask

`ifdef JSEQ_REVERSE_EN
    task automatic test_reverse();
        start = 1; num_rot = 8'd1; dir = 1;
        tick();
        start = 0; dir = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            total += 2;
            if (q !== ent(c % STEPS, 1)) begin
                bad++; $display("FAIL rev_q c=%0d got=%b want=%b", c, q, ent(c % STEPS, 1));
            end
            if (!$onehot(phase)) begin bad++; $display("FAIL rev_phase c=%0d got=%b", c, phase); end
        end
        tick();
    endtask
`endif

    task automatic test_random();
        logic [WIDTH-1:0] eq;
        logic [STEPS-1:0] ep;
        int shown = 0;
        for (int c = 0; c < 3000; c++) begin
            start   = ($urandom % 4) == 0;
            num_rot = ROT_W'($urandom % 4);
            pause   = ($urandom % 5) == 0;
            abort   = ($urandom % 40) == 0;
`ifdef JSEQ_REVERSE_EN
            dir     = 1'($urandom % 2);
`endif
            tick();
            eq = ent(m_pos, m_dir);
            ep = STEPS'(1) << m_pos;
            total += 5;
            if (q !== eq || phase !== ep || busy !== m_active || done !== m_done
                || rot_cnt !== ROT_W'(m_rot)) begin
                if (q !== eq) bad++;
                if (phase !== ep) bad++;
                if (busy !== m_active) bad++;
                if (done !== m_done) bad++;
                if (rot_cnt !== ROT_W'(m_rot)) bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random c=%0d q=%b/%b phase=%b/%b busy=%b/%b done=%b/%b rot=%0d/%0d",
                             c, q, eq, phase, ep, busy, m_active, done, m_done, rot_cnt, m_rot);
                end
            end
        end
        idle_inputs();
        for (int c = 0; c < 40; c++) tick();
    endtask

    initial begin
        test_reset();
        test_single_rot();
        test_multi_rot();
        test_zero_rot();
        test_pause();
        test_abort();
        test_max_rot();
        test_reset_midrun();
`ifdef JSEQ_REVERSE_EN
        test_reverse();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/johnson_seq_ctrl.md
JOHNSON_SEQ_CTRL -- requirements
Module: johnson_seq_ctrl

Interface
REQ-001 Parameter: WIDTH, default 4, Johnson register width, giving 2*WIDTH states per rotation; legal values are 2 or more.
REQ-002 Parameter: ROT_W, default 8, width of the rotation-count request and the rotation counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  start request; sampled only in IDLE.
REQ-006 num_rot  input  ROT_W  number of full rotations to run; latched when start is accepted.
REQ-007 pause  input  1  freezes the sequence while high.
REQ-008 abort  input  1  terminates the run.
REQ-009 q  output  WIDTH  Johnson register value.
REQ-010 phase  output  2*WIDTH  one-hot step decode of q.
REQ-011 rot_cnt  output  ROT_W  number of completed rotations.
REQ-012 busy  output  1  high in RUN and HOLD.
REQ-013 done  output  1  single-cycle completion pulse.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, HOLD and DONE.
REQ-015 In IDLE, with start=1 and num_rot!=0, the block SHALL latch num_rot, clear rot_cnt and enter RUN.
REQ-016 In IDLE, with start=1 and num_rot==0, the block SHALL go directly to DONE and leave q unchanged at 0.
REQ-017 start SHALL be ignored in any state other than IDLE.
REQ-018 The forward step SHALL be q <= {q[WIDTH-2:0], ~q[WIDTH-1]}.
- For WIDTH=4 the sequence is 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000, then back to 0000.
REQ-019 q SHALL advance on every edge where the state is RUN, pause=0 and abort=0.
- The first advance occurs one edge after start is accepted.
REQ-020 A rotation SHALL be complete when an advance returns q to 0; rot_cnt SHALL increment on that edge.
REQ-021 If rot_cnt reaches the latched num_rot on that edge, the next state SHALL be DONE.
REQ-022 In RUN with pause=1, the block SHALL enter HOLD without advancing q.
REQ-023 In HOLD with pause=0, the block SHALL return to RUN; q SHALL resume advancing on the following edge.
REQ-024 abort=1 in RUN or HOLD SHALL force IDLE and q=0 on the next edge, with no done pulse.
- abort SHALL have priority over pause and over rotation completion.
REQ-025 DONE SHALL last exactly one cycle with done=1 and then go to IDLE.
- rot_cnt SHALL hold its final value until the next accepted start.
REQ-026 phase[k] SHALL be 1 exactly when q is the k-th entry of the active sequence, for k = 0..2*WIDTH-1.
- phase is combinational from q.
REQ-027 rot_cnt SHALL NOT wrap.
- The maximum run is num_rot = 2^ROT_W - 1.
REQ-028 Busy duration SHALL be num_rot*2*WIDTH cycles plus the number of HOLD cycles.

Reset
REQ-029 rst=0 SHALL asynchronously set state=IDLE, q=0, rot_cnt=0, busy=0, done=0 and phase=1 (phase[0]=1).
REQ-030 Reset asserted mid-run SHALL discard the run with no done pulse.

Configuration
REQ-031 The macro JSEQ_REVERSE_EN SHALL control reverse stepping.
- Defined: the block SHALL add input dir (1 bit), latched at start accept.
- dir=1 SHALL select q <= {~q[0], q[WIDTH-1:1]}, giving the sequence 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001.
- With dir=1, phase SHALL decode against this reverse sequence.
- Undefined: the dir port SHALL be absent and stepping SHALL be forward only.

Structure
REQ-032 Package jseq_pkg SHALL hold the state enumeration and the default WIDTH and ROT_W constants.
REQ-033 The Johnson register and its step logic SHALL be a sub-module johnson_core.
- Ports: clk, rst, en, clr, dir; output q.
- The FSM, rotation counter and phase decode SHALL stay in johnson_seq_ctrl.

Verification
REQ-034 WIDTH=4, num_rot=1, start pulse:
- q SHALL step 0001 through 1000 and return to 0000 after 8 busy cycles.
- done SHALL pulse once and rot_cnt SHALL read 1.
REQ-035 num_rot=3:
- busy SHALL stay high for 24 cycles and rot_cnt SHALL read 1, 2, 3.
- done SHALL assert on the cycle after the 24th advance.
REQ-036 num_rot=0 start:
- done SHALL pulse on the next cycle, busy SHALL stay 0 and q SHALL stay 0000.
REQ-037 pause held for 5 cycles at q=0111:
- q SHALL hold 0111 in HOLD and busy SHALL stay 1.
- Total busy time SHALL be 8+5 cycles.
REQ-038 abort at q=1110 with pause=1:
- The next cycle SHALL be IDLE with q=0000 and no done pulse.
- A start in the following cycle SHALL be accepted.
REQ-039 With JSEQ_REVERSE_EN defined, dir=1, num_rot=1:
- q SHALL follow 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000.
- phase SHALL be one-hot throughout.
